// File: rtl/v2f_pkg.sv
// Shared types and helpers for the v2f sequential divider family.
package v2f_pkg;

  localparam int V2F_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } v2f_divmod_state_t;

  // Two's-complement negate when neg is set; callers truncate to their width.
  function automatic logic [V2F_MAX_WIDTH-1:0] v2f_abs(
    input logic [V2F_MAX_WIDTH-1:0] x,
    input logic                     neg
  );
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/v2f_divmod_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module v2f_divmod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] div_ext;

  // Compare at WIDTH+2 bits so the full partial remainder participates.
  always_comb begin
    shifted = {rem_i, bit_i};
    div_ext = {2'b00, div_i};
    q_o     = (shifted >= div_ext);
    rem_o   = q_o ? (WIDTH+1)'(shifted - div_ext) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/v2f_seq_divmod.sv
// Multi-cycle restoring divider, quotient and remainder truncated toward zero.
// Optional ABORT input enabled by defining V2F_DIVMOD_ABORT_EN.
//
// state | meaning
// IDLE  | ready for operands
// CALC  | zero-divisor check, WIDTH restoring steps, then sign correction
// DONE  | result valid, held until consumer handshake
module v2f_seq_divmod
  import v2f_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic             CLK,
  input  logic             ARST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
`ifdef V2F_DIVMOD_ABORT_EN
  ,
  input  logic             ABORT
`endif
);

  localparam int CW = $clog2(WIDTH);

  v2f_divmod_state_t state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fin_q, fin_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;  // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              dz_q, dz_d;

  logic              abort_w;
  logic              sa, sb;
  logic [WIDTH:0]    step_rem;
  logic              step_q;

`ifdef V2F_DIVMOD_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif

  assign sa = SIGNED ? A[WIDTH-1] : 1'b0;
  assign sb = SIGNED ? B[WIDTH-1] : 1'b0;

  v2f_divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .div_i (dvs_q),
    .bit_i (dvd_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state and datapath update; the zero-divisor test uses the latched
  // divisor so results always come from registered operands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          dvd_d   = WIDTH'(v2f_abs(V2F_MAX_WIDTH'(A), sa));
          dvs_d   = WIDTH'(v2f_abs(V2F_MAX_WIDTH'(B), sb));
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          fin_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort_w) begin
          state_d = IDLE;
        end else if (dvs_q == '0) begin
          q_d     = '0;
          r_d     = '0;
          dz_d    = 1'b1;
          state_d = DONE;
        end else if (fin_q) begin
          q_d     = WIDTH'(v2f_abs(V2F_MAX_WIDTH'(dvd_q), qneg_q));
          r_d     = WIDTH'(v2f_abs(V2F_MAX_WIDTH'(rem_q[WIDTH-1:0]), rneg_q));
          dz_d    = 1'b0;
          state_d = DONE;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          if (cnt_q == '0) fin_d = 1'b1;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (abort_w || OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign DZ        = dz_q;

endmodule
